// File: rtl/rpn_core_pkg.sv
// Shared definitions for the RPN calculator core: opcodes, error codes,
// FSM states and small opcode-classification helpers.
package rpn_core_pkg;

   // Opcodes
   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_PUSH   = 4'd1;
   localparam logic [3:0] OP_APPEND = 4'd2;
   localparam logic [3:0] OP_ADD    = 4'd3;
   localparam logic [3:0] OP_SUB    = 4'd4;
   localparam logic [3:0] OP_MUL    = 4'd5;
   localparam logic [3:0] OP_DIV    = 4'd6;
   localparam logic [3:0] OP_MOD    = 4'd7;
   localparam logic [3:0] OP_POP    = 4'd8;
   localparam logic [3:0] OP_DUP    = 4'd9;
   localparam logic [3:0] OP_SWAP   = 4'd10;
   localparam logic [3:0] OP_OVER   = 4'd11;
   localparam logic [3:0] OP_CLEAR  = 4'd12;

   // Error codes reported on rsp_err
   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
   localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
   localparam logic [2:0] ERR_DIVZERO   = 3'd3;
   localparam logic [2:0] ERR_BADOP     = 3'd4;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_DIV_RUN = 2'd2,
      ST_DIV_END = 2'd3
   } state_t;

   // Opcodes 13..15 have no meaning
   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_CLEAR;
   endfunction

   // Number of stack entries an opcode consumes as operands
   function automatic logic [1:0] operands_needed(input logic [3:0] op);
      logic [1:0] n;
      n = 2'd0;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_SWAP, OP_OVER: n = 2'd2;
         OP_APPEND, OP_POP, OP_DUP:                                n = 2'd1;
         default:                                                  n = 2'd0;
      endcase
      return n;
   endfunction

   // Opcodes that add one entry to the stack
   function automatic logic op_grows(input logic [3:0] op);
      return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
   endfunction

   // Opcodes that go through the multi-cycle divider
   function automatic logic op_is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/rpn_div.sv
// Restoring unsigned divider. One quotient bit per cycle; output_vld pulses
// BITS+1 cycles after input_vld, with Q/R held stable afterwards.
module rpn_div #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BITS-1:0] A,
   input  logic [BITS-1:0] B,
   input  logic            input_vld,
   output logic [BITS-1:0] Q,
   output logic [BITS-1:0] R,
   output logic            output_vld
);

   localparam int CNT_W = $clog2(BITS + 1);

   logic [BITS-1:0]  d_q;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic [BITS:0]    shifted;
   logic [BITS:0]    diff;

   // Partial remainder shifted left by one dividend bit, then trial-subtracted.
   // A set MSB in diff means the subtraction borrowed, so the remainder is restored.
   assign shifted = {R, Q[BITS-1]};
   assign diff    = shifted - {1'b0, d_q};

   // Load operands, then iterate BITS times; Q shifts dividend out and quotient in
   always_ff @(posedge clk) begin
      if (reset) begin
         Q          <= '0;
         R          <= '0;
         d_q        <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         output_vld <= 1'b0;
      end else begin
         output_vld <= 1'b0;
         if (input_vld) begin
            Q    <= A;
            R    <= '0;
            d_q  <= B;
            cnt  <= CNT_W'(BITS);
            busy <= 1'b1;
         end else if (busy) begin
            if (diff[BITS]) begin
               R <= shifted[BITS-1:0];
               Q <= {Q[BITS-2:0], 1'b0};
            end else begin
               R <= diff[BITS-1:0];
               Q <= {Q[BITS-2:0], 1'b1};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy       <= 1'b0;
               output_vld <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rpn_core.sv
// RPN stack-calculator engine. Executes one command per handshake on a
// DEPTH-entry stack held in a register array plus a registered top copy.
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
// cmd_op/cmd_data are sampled only then. cmd_ready is low from the cycle after
// acceptance until the rsp_done cycle, so at most one command is in flight.
module rpn_core
   import rpn_core_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 64,
   parameter int APPEND_W = 8,
   parameter int SIZE_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_done,
   output logic [2:0]        rsp_err,
   output logic [DATA_W-1:0] top,
   output logic [SIZE_W-1:0] size,
   output logic              empty,
   output logic              full,
   output logic [1:0]        dbg_state
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DATA_W);

   state_t            state;
   logic [3:0]        op_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] top_q;
   logic [SIZE_W-1:0] size_q;
   logic [CNT_W-1:0]  div_cnt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  idx_top;
   logic [IDX_W-1:0]  idx_sec;
   logic [IDX_W-1:0]  idx_new;
   logic [DATA_W-1:0] second;

   logic [2:0]        exec_err;
   logic              is_div;
   logic              div_start;
   logic              stack_upd;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] append_val;

   logic              wr0_en;
   logic [IDX_W-1:0]  wr0_idx;
   logic [DATA_W-1:0] wr0_dat;
   logic              wr1_en;
   logic [IDX_W-1:0]  wr1_idx;
   logic [DATA_W-1:0] wr1_dat;
   logic [SIZE_W-1:0] nxt_size;
   logic [DATA_W-1:0] nxt_top;

   logic [DATA_W-1:0] div_q;
   logic [DATA_W-1:0] div_r;
   logic              div_vld;

   // Entry 0 is the bottom; the top lives at size-1 (and in top_q)
   assign idx_top = size_q[IDX_W-1:0] - IDX_W'(1);
   assign idx_sec = size_q[IDX_W-1:0] - IDX_W'(2);
   assign idx_new = size_q[IDX_W-1:0];
   assign second  = mem[idx_sec];

   assign is_div     = op_is_div(op_q);
   assign append_val = {top_q[DATA_W-APPEND_W-1:0], data_q[APPEND_W-1:0]};

   assign top       = top_q;
   assign size      = size_q;
   assign empty     = (size_q == '0);
   assign full      = (size_q == SIZE_W'(DEPTH));
   assign dbg_state = state;

   // Error classification of the latched command, highest priority first
   always_comb begin
      exec_err = ERR_NONE;
      if (!op_legal(op_q))
         exec_err = ERR_BADOP;
      else if (size_q < SIZE_W'(operands_needed(op_q)))
         exec_err = ERR_UNDERFLOW;
      else if (op_grows(op_q) && full)
         exec_err = ERR_OVERFLOW;
      else if (is_div && (top_q == '0))
         exec_err = ERR_DIVZERO;
   end

   // Single-cycle arithmetic on a = second, b = top
   always_comb begin
      alu_res = '0;
      case (op_q)
         OP_ADD:  alu_res = second + top_q;
         OP_SUB:  alu_res = second - top_q;
         OP_MUL:  alu_res = DATA_W'(second * top_q);
         default: alu_res = '0;
      endcase
   end

   assign div_start = (state == ST_EXEC) && (exec_err == ERR_NONE) && is_div;
   assign stack_upd = ((state == ST_EXEC) && (exec_err == ERR_NONE) && !is_div) ||
                      ((state == ST_DIV_END) && div_vld);

   // Stack write ports and next size/top for a successful command
   always_comb begin
      wr0_en   = 1'b0;
      wr0_idx  = idx_top;
      wr0_dat  = '0;
      wr1_en   = 1'b0;
      wr1_idx  = idx_sec;
      wr1_dat  = '0;
      nxt_size = size_q;
      nxt_top  = top_q;
      if (state == ST_DIV_END) begin
         wr0_en   = 1'b1;
         wr0_idx  = idx_sec;
         wr0_dat  = (op_q == OP_DIV) ? div_q : div_r;
         nxt_size = size_q - SIZE_W'(1);
         nxt_top  = wr0_dat;
      end else begin
         case (op_q)
            OP_PUSH: begin
               wr0_en   = 1'b1;
               wr0_idx  = idx_new;
               wr0_dat  = data_q;
               nxt_size = size_q + SIZE_W'(1);
               nxt_top  = data_q;
            end
            OP_APPEND: begin
               wr0_en  = 1'b1;
               wr0_idx = idx_top;
               wr0_dat = append_val;
               nxt_top = append_val;
            end
            OP_ADD, OP_SUB, OP_MUL: begin
               wr0_en   = 1'b1;
               wr0_idx  = idx_sec;
               wr0_dat  = alu_res;
               nxt_size = size_q - SIZE_W'(1);
               nxt_top  = alu_res;
            end
            OP_POP: begin
               nxt_size = size_q - SIZE_W'(1);
               nxt_top  = (size_q == SIZE_W'(1)) ? '0 : second;
            end
            OP_DUP: begin
               wr0_en   = 1'b1;
               wr0_idx  = idx_new;
               wr0_dat  = top_q;
               nxt_size = size_q + SIZE_W'(1);
            end
            OP_SWAP: begin
               wr0_en  = 1'b1;
               wr0_idx = idx_top;
               wr0_dat = second;
               wr1_en  = 1'b1;
               wr1_idx = idx_sec;
               wr1_dat = top_q;
               nxt_top = second;
            end
            OP_OVER: begin
               wr0_en   = 1'b1;
               wr0_idx  = idx_new;
               wr0_dat  = second;
               nxt_size = size_q + SIZE_W'(1);
               nxt_top  = second;
            end
            OP_CLEAR: begin
               nxt_size = '0;
               nxt_top  = '0;
            end
            default: ;
         endcase
      end
   end

   // Stack storage; contents are meaningless outside 0..size-1, so no reset
   always_ff @(posedge clk) begin
      if (stack_upd && wr0_en)
         mem[wr0_idx] <= wr0_dat;
      if (stack_upd && wr1_en)
         mem[wr1_idx] <= wr1_dat;
   end

   // Command controller: accept, execute or run the divider, then retire
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b1;
         rsp_done  <= 1'b0;
         rsp_err   <= ERR_NONE;
         size_q    <= '0;
         top_q     <= '0;
         op_q      <= OP_NOP;
         data_q    <= '0;
         div_cnt   <= '0;
      end else begin
         rsp_done <= 1'b0;
         if (stack_upd) begin
            size_q <= nxt_size;
            top_q  <= nxt_top;
         end
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_q      <= cmd_op;
                  data_q    <= cmd_data;
                  cmd_ready <= 1'b0;
                  state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (exec_err == ERR_NONE && is_div) begin
                  // Divider was started this cycle; DIV_END lines up with its result
                  div_cnt <= CNT_W'(DATA_W - 1);
                  state   <= ST_DIV_RUN;
               end else begin
                  rsp_done  <= 1'b1;
                  rsp_err   <= exec_err;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_DIV_RUN: begin
               if (div_cnt == '0)
                  state <= ST_DIV_END;
               else
                  div_cnt <= div_cnt - CNT_W'(1);
            end
            ST_DIV_END: begin
               if (div_vld) begin
                  rsp_done  <= 1'b1;
                  rsp_err   <= ERR_NONE;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rpn_div #(
      .BITS(DATA_W)
   ) u_div (
      .clk       (clk),
      .reset     (reset),
      .A         (second),
      .B         (top_q),
      .input_vld (div_start),
      .Q         (div_q),
      .R         (div_r),
      .output_vld(div_vld)
   );

endmodule
